imem_loader: RTL and testbench

- Write-side companion to the single-cycle core's instruction ROM.
- Receives a program as a byte stream with a valid/ready handshake and assembles the bytes into 32-bit instruction words.
- Issues one write per word into a writable instruction memory, using byte addresses (the memory indexes by Address[7:2]).
- Holds the CPU in reset until the image is fully loaded, then releases it.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction-memory write bus bundle for imem_loader
//
// Signals:
//   in_valid  source -> loader  in_data holds a byte
//   in_data   source -> loader  stream byte
//   in_ready  loader -> source  loader accepts a byte this cycle
//   wr_en     loader -> memory  one-cycle write strobe
//   wr_addr   loader -> memory  word-aligned byte address
//   wr_data   loader -> memory  instruction word
// Modports:
//   master  byte source / memory side (drives the stream, observes the write bus)
//   slave   the loader itself
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte-streamed program image into instruction memory, holding the core in reset until done
//
// Image format: one header byte N (word count, 1..DEPTH), then 4*N data bytes,
// each word sent MSB first. Words are written at byte addresses 0, 4, 8, ...
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   bus           imem_loader_if.slave: in_valid/in_data/in_ready byte stream in,
//                 wr_en/wr_addr/wr_data instruction-memory write out
//   cpu_hold      high holds the core in reset
//   done          load completed successfully
//   err           load aborted (bad header or bad checksum); sticky until reset
//   words_loaded  number of words written so far
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last word one extra
// byte is accepted and compared against the XOR of all data bytes.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       byte_idx;
    // Only the first three bytes of a word need storing; the fourth goes
    // straight from in_data into wr_data.
    logic [23:0]      word_buf;
    logic             accept;
    logic [CNT_W-1:0] next_count;
    logic             header_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept     = bus.in_valid && bus.in_ready;
    assign next_count = words_loaded + CNT_W'(1);
    assign header_bad = (bus.in_data == 8'd0) || (32'(bus.in_data) > DEPTH);

    // in_ready is registered, so every transition sets it for the state being
    // entered; a state that accepts bytes keeps re-asserting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HEADER;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= 32'd0;
            bus.wr_data  <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            word_count   <= '0;
            byte_idx     <= 2'd0;
            word_buf     <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_HEADER: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        if (header_bad) begin
                            state        <= S_ERROR;
                            bus.in_ready <= 1'b0;
                            err          <= 1'b1;
                        end else begin
                            word_count <= CNT_W'(bus.in_data);
                            state      <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        word_buf <= {word_buf[15:0], bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.in_data;
`endif
                        if (byte_idx == 2'd3) begin
                            byte_idx     <= 2'd0;
                            bus.in_ready <= 1'b0;
                            bus.wr_en    <= 1'b1;
                            bus.wr_addr  <= {{(30 - CNT_W){1'b0}}, words_loaded, 2'b00};
                            bus.wr_data  <= {word_buf, bus.in_data};
                            state        <= S_WRITE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end

                S_WRITE: begin
                    words_loaded <= next_count;
                    if (next_count == word_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state        <= S_CHECK;
                        bus.in_ready <= 1'b1;
`else
                        state        <= S_DONE;
                        bus.in_ready <= 1'b0;
                        done         <= 1'b1;
                        cpu_hold     <= 1'b0;
`endif
                    end else begin
                        state        <= S_DATA;
                        bus.in_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE: begin
                    bus.in_ready <= 1'b0;
                end

                S_ERROR: begin
                    bus.in_ready <= 1'b0;
                end

                default: begin
                    state        <= S_ERROR;
                    bus.in_ready <= 1'b0;
                    err          <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [6:0] words_loaded;

    int vectors;
    int miscompares;
    int ready_in_write;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader_if ifc ();

    imem_loader #(.DEPTH(64), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (ifc.slave),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.wr_en === 1'b1) begin
                wq_addr.push_back(ifc.wr_addr);
                wq_data.push_back(ifc.wr_data);
                if (ifc.in_ready !== 1'b0) ready_in_write++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        ready_in_write = 0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data = b;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted, in_ready=%b", b, ifc.in_ready);
            ifc.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ifc.in_valid = 1'b0;
        end
    endtask

    task automatic send_checksum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        b = b;
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ifc.in_ready, ifc.wr_en, done, err, cpu_hold} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/wr/done/err/hold=%b exp 00001",
                     {ifc.in_ready, ifc.wr_en, done, err, cpu_hold});
        end
        vectors++;
        if ({ifc.wr_addr, ifc.wr_data, words_loaded} !== 71'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got addr=%h data=%h wl=%0d exp 0",
                     ifc.wr_addr, ifc.wr_data, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (ifc.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_header_ready: got in_ready=%b exp 1", ifc.in_ready);
        end
    endtask

    task automatic test_basic();
        logic rdy_seen;
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
        vectors++;
        if (ifc.wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: got wr_en=%b exp 1 after 4th byte", ifc.wr_en);
        end
        send_byte(8'h20, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h0A, 0);
        send_checksum(8'h1B);
        repeat (3) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 2) begin
            miscompares++;
            $display("FAIL basic_write_count: got %0d exp 2", wq_addr.size());
        end else begin
            vectors++;
            if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h20080010) begin
                miscompares++;
                $display("FAIL basic_write0: got %h/%h exp 00000000/20080010", wq_addr[0], wq_data[0]);
            end
            vectors++;
            if (wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h2009000A) begin
                miscompares++;
                $display("FAIL basic_write1: got %h/%h exp 00000004/2009000a", wq_addr[1], wq_data[1]);
            end
        end
        vectors++;
        if ({done, cpu_hold, err, words_loaded} !== {1'b1, 1'b0, 1'b0, 7'd2}) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b hold=%b err=%b wl=%0d exp 1 0 0 2",
                     done, cpu_hold, err, words_loaded);
        end
        vectors++;
        if (ready_in_write !== 0) begin
            miscompares++;
            $display("FAIL basic_ready_in_write: got %0d cycles exp 0", ready_in_write);
        end
        // Bytes offered after DONE must be refused.
        rdy_seen = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data = 8'h55;
        repeat (5) begin
            @(negedge clk);
            rdy_seen = rdy_seen | ifc.in_ready;
        end
        ifc.in_valid = 1'b0;
        vectors++;
        if (rdy_seen !== 1'b0 || wq_addr.size() !== 2 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_refuses: got ready=%b writes=%0d done=%b exp 0 2 1",
                     rdy_seen, wq_addr.size(), done);
        end
    endtask

    task automatic test_header_zero();
        do_reset();
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({err, cpu_hold, ifc.in_ready, done} !== 4'b1100 || wq_addr.size() !== 0) begin
            miscompares++;
            $display("FAIL header_zero: got err/hold/rdy/done=%b writes=%0d exp 1100 0",
                     {err, cpu_hold, ifc.in_ready, done}, wq_addr.size());
        end
    endtask

    task automatic test_header_large();
        int bad;
        do_reset();
        send_byte(8'h41, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({err, cpu_hold, ifc.in_ready} !== 3'b110 || wq_addr.size() !== 0) begin
            miscompares++;
            $display("FAIL header_65: got err/hold/rdy=%b writes=%0d exp 110 0",
                     {err, cpu_hold, ifc.in_ready}, wq_addr.size());
        end
        do_reset();
        send_byte(8'h40, 0);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        send_checksum(8'h00);
        repeat (3) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 64) begin
            miscompares++;
            $display("FAIL full_write_count: got %0d exp 64", wq_addr.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 64; k++) begin
                if (wq_addr[k] !== 32'(k * 4)) bad++;
                if (wq_data[k] !== {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}) bad++;
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL full_write_contents: %0d bad fields exp 0", bad);
            end
            vectors++;
            if (wq_addr[63] !== 32'hFC || wq_data[63] !== 32'hFCFDFEFF) begin
                miscompares++;
                $display("FAIL full_last_write: got %h/%h exp 000000fc/fcfdfeff", wq_addr[63], wq_data[63]);
            end
        end
        vectors++;
        if ({done, err, cpu_hold, words_loaded} !== {1'b1, 1'b0, 1'b0, 7'd64}) begin
            miscompares++;
            $display("FAIL full_done: got done=%b err=%b hold=%b wl=%0d exp 1 0 0 64",
                     done, err, cpu_hold, words_loaded);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h88, 3); send_byte(8'h20, 3);
        send_checksum(8'hA8);
        repeat (3) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 1) begin
            miscompares++;
            $display("FAIL gaps_write_count: got %0d exp 1", wq_addr.size());
        end else begin
            vectors++;
            if (wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h00008820) begin
                miscompares++;
                $display("FAIL gaps_write: got %h/%h exp 00000000/00008820", wq_addr[0], wq_data[0]);
            end
        end
        vectors++;
        if (done !== 1'b1 || ready_in_write !== 0) begin
            miscompares++;
            $display("FAIL gaps_done: got done=%b ready_in_write=%0d exp 1 0", done, ready_in_write);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 1 || wq_data[0] !== 32'h11223344) begin
            miscompares++;
            $display("FAIL mid_first_write: got writes=%0d exp 1 with data 11223344", wq_addr.size());
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({cpu_hold, ifc.in_ready, words_loaded} !== {1'b1, 1'b0, 7'd0}) begin
            miscompares++;
            $display("FAIL mid_reset: got hold=%b rdy=%b wl=%0d exp 1 0 0",
                     cpu_hold, ifc.in_ready, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk);
        #1;
        vectors++;
        if (ifc.in_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_header_ready: got rdy=%b done=%b exp 1 0", ifc.in_ready, done);
        end
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        send_checksum(8'h00);
        repeat (3) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 1 || wq_addr[0] !== 32'h0 || wq_data[0] !== 32'hAABBCCDD || done !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reload: got writes=%0d done=%b exp 1 write aabbccdd at 0, done 1",
                     wq_addr.size(), done);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h0F, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, err, cpu_hold} !== 3'b100) begin
            miscompares++;
            $display("FAIL csum_good: got done/err/hold=%b exp 100", {done, err, cpu_hold});
        end
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h0E, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, err, cpu_hold} !== 3'b011) begin
            miscompares++;
            $display("FAIL csum_bad: got done/err/hold=%b exp 011", {done, err, cpu_hold});
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        ready_in_write = 0;
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data = 8'h00;
        test_reset();
        test_basic();
        test_header_zero();
        test_header_large();
        test_gaps();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
